// File: rtl/typing_pkg.sv
// Shared types and constants for the typing-round scorer.
//   state_t : round FSM states (IDLE, RUN, DONE)
//   bcd_t   : one BCD digit
//   BCD_MAX : largest legal BCD digit value
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter_sat.sv
// Multi-digit BCD up-counter that saturates at all-9s.
// Ports:
//   clk      : clock, state updates on posedge
//   reset_n  : asynchronous active-low reset, clears the count
//   clr      : synchronous clear, takes priority over inc
//   inc      : add one this cycle (ignored once the count is all-9s)
//   count    : packed digits [0:DIGITS-1][3:0], index 0 = least-significant digit
module bcd_counter_sat
  import typing_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [0:DIGITS-1][3:0]  count
);

  logic [0:DIGITS-1][3:0] r_count;
  logic [0:DIGITS-1][3:0] w_count_d;
  logic                   w_all_max;

  always_comb begin
    logic v_carry;
    w_all_max = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_count[i] != BCD_MAX) w_all_max = 1'b0;
    end
    w_count_d = r_count;
    // Ripple the increment up through the digits; blocked entirely at all-9s.
    v_carry = inc & ~w_all_max;
    for (int i = 0; i < DIGITS; i++) begin
      if (v_carry) begin
        if (r_count[i] == BCD_MAX) begin
          w_count_d[i] = '0;
        end else begin
          w_count_d[i] = r_count[i] + 4'd1;
          v_carry      = 1'b0;
        end
      end
    end
    if (clr) w_count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/typing_score.sv
// Scores a one-minute typing round: compares accepted keystrokes against the current
// target character and keeps saturating BCD counts of hits (and optionally misses).
// Optional feature macro: MISS_COUNT_EN (adds the miss counter; otherwise miss_bcd = 0).
// Ports:
//   clk, reset_n    : clock / asynchronous active-low reset
//   start           : pulse, clear counters and (re)start the round
//   time_up         : pulse from the round timer, ends the round
//   key_valid/ready : keystroke handshake (ready is always high)
//   key_code        : keystroke character
//   expect_code     : current target character
//   expect_advance  : one-cycle pulse after a correct key, fetch next target
//   running, done   : registered state flags
//   score_bcd       : correct-key count, [0:DIGITS-1][3:0], digit 0 least significant
//   miss_bcd        : miss count (zero when MISS_COUNT_EN is not defined)
module typing_score
  import typing_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CHAR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   time_up,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [CHAR_W-1:0]      key_code,
  input  logic [CHAR_W-1:0]      expect_code,
  output logic                   expect_advance,
  output logic                   running,
  output logic                   done,
  output logic [0:DIGITS-1][3:0] score_bcd,
  output logic [0:DIGITS-1][3:0] miss_bcd
);

  state_t r_state;
  state_t w_state_d;
  logic   r_running;
  logic   r_done;
  logic   r_advance;
  logic   w_count_en;
  logic   w_hit;

  // Keys are always consumed; outside RUN they are simply dropped.
  assign key_ready = 1'b1;

  // start and time_up both outrank a keystroke in the same cycle.
  assign w_count_en = (r_state == RUN) & key_valid & key_ready & ~start & ~time_up;
  assign w_hit      = w_count_en & (key_code == expect_code);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_d = RUN;
      RUN: begin
        if (start)        w_state_d = RUN;
        else if (time_up) w_state_d = DONE;
      end
      DONE:    if (start) w_state_d = RUN;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_advance <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_running <= (w_state_d == RUN);
      r_done    <= (w_state_d == DONE);
      r_advance <= w_hit;
    end
  end

  assign running        = r_running;
  assign done           = r_done;
  assign expect_advance = r_advance;

  bcd_counter_sat #(
    .DIGITS (DIGITS)
  ) u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .inc     (w_hit),
    .count   (score_bcd)
  );

`ifdef MISS_COUNT_EN
  logic w_miss;
  assign w_miss = w_count_en & (key_code != expect_code);

  bcd_counter_sat #(
    .DIGITS (DIGITS)
  ) u_miss (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .inc     (w_miss),
    .count   (miss_bcd)
  );
`else
  assign miss_bcd = '0;
`endif

endmodule

// File: tb/tb_typing_score.sv
module tb_typing_score;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             time_up;
  logic             key_valid;
  logic             key_ready;
  logic [7:0]       key_code;
  logic [7:0]       expect_code;
  logic             expect_advance;
  logic             running;
  logic             done;
  logic [0:3][3:0]  score_bcd;
  logic [0:3][3:0]  miss_bcd;

  int n_checks = 0;
  int n_errors = 0;
  int adv_pulses;

  typing_score #(
    .DIGITS (4),
    .CHAR_W (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .time_up        (time_up),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .key_code       (key_code),
    .expect_code    (expect_code),
    .expect_advance (expect_advance),
    .running        (running),
    .done           (done),
    .score_bcd      (score_bcd),
    .miss_bcd       (miss_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display a BCD counter as a 16-bit hex word reading like the 7-segment display.
  function automatic logic [15:0] bcd_val(input logic [0:3][3:0] d);
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    time_up   = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One keystroke, then one idle cycle so expect_advance is seen as a separate pulse.
  task automatic key_gap(input logic match);
    key_valid = 1'b1;
    key_code  = match ? expect_code : (expect_code ^ 8'h01);
    tick();
    if (expect_advance) adv_pulses++;
    key_valid = 1'b0;
    tick();
    if (expect_advance) adv_pulses++;
  endtask

  logic [15:0] exp_miss;

  initial begin
    reset_n     = 1'b0;
    expect_code = 8'h41;
    key_code    = 8'h00;
    idle_inputs();
    tick();
    tick();
    check("rst_score", 32'(bcd_val(score_bcd)), 32'h0);
    check("rst_miss", 32'(bcd_val(miss_bcd)), 32'h0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(key_ready), 32'd1);
    check("rst_adv", 32'(expect_advance), 32'd0);
    reset_n = 1'b1;
    tick();

    // Key in IDLE is dropped.
    key_valid = 1'b1;
    key_code  = expect_code;
    tick();
    key_valid = 1'b0;
    check("idle_key_drop", 32'(bcd_val(score_bcd)), 32'h0);

    // 1: build score 0042 then async reset mid-RUN.
    pulse_start();
    check("start_running", 32'(running), 32'd1);
    key_valid = 1'b1;
    key_code  = expect_code;
    repeat (42) tick();
    key_valid = 1'b0;
    check("score_42", 32'(bcd_val(score_bcd)), 32'h0042);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_score", 32'(bcd_val(score_bcd)), 32'h0);
    check("async_running", 32'(running), 32'd0);
    check("async_ready", 32'(key_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_running", 32'(running), 32'd0);

    // 2: three hits, two misses.
    pulse_start();
    adv_pulses = 0;
    for (int i = 0; i < 3; i++) key_gap(1'b1);
    for (int i = 0; i < 2; i++) key_gap(1'b0);
    check("t2_score", 32'(bcd_val(score_bcd)), 32'h0003);
`ifdef MISS_COUNT_EN
    exp_miss = 16'h0002;
`else
    exp_miss = 16'h0000;
`endif
    check("t2_miss", 32'(bcd_val(miss_bcd)), 32'(exp_miss));
    check("t2_adv_pulses", 32'(adv_pulses), 32'd3);

    // Back-to-back hit then check advance follows exactly the next cycle.
    key_valid = 1'b1;
    key_code  = expect_code;
    tick();
    key_valid = 1'b0;
    check("adv_hi", 32'(expect_advance), 32'd1);
    check("t2b_score", 32'(bcd_val(score_bcd)), 32'h0004);
    tick();
    check("adv_lo", 32'(expect_advance), 32'd0);

    // 3: match together with time_up -> dropped, DONE.
    key_valid = 1'b1;
    key_code  = expect_code;
    time_up   = 1'b1;
    tick();
    time_up = 1'b0;
    check("t3_score", 32'(bcd_val(score_bcd)), 32'h0004);
    check("t3_done", 32'(done), 32'd1);
    check("t3_running", 32'(running), 32'd0);
    check("t3_adv", 32'(expect_advance), 32'd0);
    repeat (3) tick();
    key_valid = 1'b0;
    check("t3_after_score", 32'(bcd_val(score_bcd)), 32'h0004);
    check("t3_hold_done", 32'(done), 32'd1);

    // DONE -> RUN on start clears counters.
    pulse_start();
    check("restart_score", 32'(bcd_val(score_bcd)), 32'h0);
    check("restart_running", 32'(running), 32'd1);
    check("restart_done", 32'(done), 32'd0);

    // 4: carry chain and saturation.
    key_valid = 1'b1;
    key_code  = expect_code;
    repeat (999) tick();
    check("t4_0999", 32'(bcd_val(score_bcd)), 32'h0999);
    tick();
    check("t4_1000", 32'(bcd_val(score_bcd)), 32'h1000);
    repeat (8999) tick();
    check("t4_9999", 32'(bcd_val(score_bcd)), 32'h9999);
    repeat (5) tick();
    key_valid = 1'b0;
    check("t4_sat", 32'(bcd_val(score_bcd)), 32'h9999);

    // 5: start and time_up in the same RUN cycle -> restart wins.
    start   = 1'b1;
    time_up = 1'b1;
    tick();
    idle_inputs();
    check("t5_score", 32'(bcd_val(score_bcd)), 32'h0);
    check("t5_running", 32'(running), 32'd1);
    check("t5_done", 32'(done), 32'd0);

    // 6: four mismatches.
    key_gap(1'b1);
    for (int i = 0; i < 4; i++) key_gap(1'b0);
`ifdef MISS_COUNT_EN
    exp_miss = 16'h0004;
`else
    exp_miss = 16'h0000;
`endif
    check("t6_miss", 32'(bcd_val(miss_bcd)), 32'(exp_miss));
    check("t6_score", 32'(bcd_val(score_bcd)), 32'h0001);
    check("t6_ready", 32'(key_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
